gift_sbox_layer_sched: RTL and testbench

Sequencer for one shared 3-share second-order masked GIFT S-box stage: serializes all nibbles of a masked GIFT state through the single S-box datapath, one nibble per cycle. It sits between the round-state registers and the S-box instance:
- fetches 8 fresh random bits per nibble from the PRNG via a valid/ready handshake;
- drives the S-box inputs and randomness with correct per-cycle alignment;
- reassembles the three output share words and pulses `done`.

---
 rtl/gift_sbox_layer_sched.sv | 94 +++++++++
 tb/tb_gift_sbox_layer_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gift_sbox_layer_sched.sv
// gift_sbox_layer_sched: serializes a 3-share masked GIFT state through one shared S-box, one nibble per cycle
// Ports: start/busy/done control; st_in1..3 -> st_out1..3 state shares (4*NIB bits);
//   rnd_valid/rnd_data/rnd_ready PRNG handshake; sb_in1..3/sb_r to the S-box, sb_out1..3 back (1-cycle latency).
// Build option: GIFT_SBOX_SCHED_CLR_EN clears st_out1..3 when a layer is accepted.
module gift_sbox_layer_sched #(
  parameter int NIB = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NIB-1:0]  st_in1,
  input  logic [4*NIB-1:0]  st_in2,
  input  logic [4*NIB-1:0]  st_in3,
  output logic              busy,
  output logic              done,
  output logic [4*NIB-1:0]  st_out1,
  output logic [4*NIB-1:0]  st_out2,
  output logic [4*NIB-1:0]  st_out3,
  input  logic              rnd_valid,
  input  logic [7:0]        rnd_data,
  output logic              rnd_ready,
  output logic [3:0]        sb_in1,
  output logic [3:0]        sb_in2,
  output logic [3:0]        sb_in3,
  output logic [7:0]        sb_r,
  input  logic [3:0]        sb_out1,
  input  logic [3:0]        sb_out2,
  input  logic [3:0]        sb_out3
);
  localparam int W = 4*NIB;
  localparam int KW = $clog2(NIB);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [KW-1:0] k, k_d;
  logic [W-1:0] s1, s2, s3;
  logic [3:0] rlo;
  logic iss_d, issue;
  // Bubbles force the S-box inputs to zero so no partial share ever enters the datapath.
  always_comb begin
    issue = state == RUN && rnd_valid;
    rnd_ready = issue;
    busy = state == RUN || state == FLUSH;
    done = state == DONE;
    sb_in1 = issue ? s1[4*k +: 4] : 4'h0;
    sb_in2 = issue ? s2[4*k +: 4] : 4'h0;
    sb_in3 = issue ? s3[4*k +: 4] : 4'h0;
    sb_r = {issue ? rnd_data[7:4] : 4'h0, rlo};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      k_d <= '0;
      rlo <= '0;
      iss_d <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      st_out1 <= '0;
      st_out2 <= '0;
      st_out3 <= '0;
    end else begin
      // Low random nibble is held for the output-stage remasking of the nibble just issued.
      rlo <= issue ? rnd_data[3:0] : 4'h0;
      iss_d <= issue;
      k_d <= k;
      if (iss_d) begin
        st_out1[4*k_d +: 4] <= sb_out1;
        st_out2[4*k_d +: 4] <= sb_out2;
        st_out3[4*k_d +: 4] <= sb_out3;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          k <= '0;
          s1 <= st_in1;
          s2 <= st_in2;
          s3 <= st_in3;
`ifdef GIFT_SBOX_SCHED_CLR_EN
          st_out1 <= '0;
          st_out2 <= '0;
          st_out3 <= '0;
`else
`endif
        end
        RUN: if (issue) begin
          k <= k + 1'b1;
          if (k == KW'(NIB-1)) state <= FLUSH;
        end
        FLUSH: state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gift_sbox_layer_sched.sv
// tb_gift_sbox_layer_sched: randomized check of the GIFT S-box layer sequencer against a nibble-level model
module tb_gift_sbox_layer_sched;
  localparam int NIB = 16;
  localparam int W = 4*NIB;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] st_in1 = '0, st_in2 = '0, st_in3 = '0;
  logic busy, done, rnd_ready;
  logic [W-1:0] st_out1, st_out2, st_out3;
  logic rnd_valid = 1'b0;
  logic [7:0] rnd_data = '0;
  logic [3:0] sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
  logic [7:0] sb_r;
  logic [W-1:0] prev1 = '0, prev2 = '0, prev3 = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gift_sbox_layer_sched #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .st_in1(st_in1), .st_in2(st_in2), .st_in3(st_in3),
    .busy(busy), .done(done),
    .st_out1(st_out1), .st_out2(st_out2), .st_out3(st_out3),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
  );
  always_ff @(posedge clk) begin
    sb_out1 <= sb_in1;
    sb_out2 <= sb_in2;
    sb_out3 <= sb_in3;
  end
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_ready", W'(rnd_ready), 0);
    chk("rst_sbin", W'({sb_in1, sb_in2, sb_in3}), 0);
    chk("rst_sbr", W'(sb_r), 0);
    chk("rst_out1", st_out1, 0);
    chk("rst_out2", st_out2, 0);
    chk("rst_out3", st_out3, 0);
  endtask
  // mode 0: always valid, 1: bubbles in cycles E0+3 and E0+10, 2: random valid and random start noise
  task automatic run_layer(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                           input int mode, input int abort_at);
    int n = 0, cyc = 0, bub = 0;
    logic v, iss;
    logic [7:0] d;
    logic [3:0] plo = 4'h0;
    @(posedge clk); #1;
    start = 1'b1; st_in1 = a; st_in2 = b; st_in3 = c;
    @(posedge clk); #1;
    st_in1 = {$urandom, $urandom}; st_in2 = {$urandom, $urandom}; st_in3 = {$urandom, $urandom};
    while (n < NIB && cyc < 200) begin
      cyc++;
      v = mode == 1 ? !(cyc == 3 || cyc == 10) : mode == 2 ? $urandom_range(0, 3) != 0 : 1'b1;
      d = n == 4 ? 8'hA5 : 8'($urandom);
      start = mode == 2 ? 1'($urandom_range(0, 1)) : cyc == 5;
      rnd_valid = v; rnd_data = d;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; rnd_valid = 1'b0;
        prev1 = '0; prev2 = '0; prev3 = '0;
        return;
      end
      @(negedge clk);
      iss = v;
      chk("busy", W'(busy), 1);
      chk("done_early", W'(done), 0);
      chk("ready", W'(rnd_ready), W'(iss));
      chk("sb_in1", W'(sb_in1), iss ? W'(a[4*n +: 4]) : 0);
      chk("sb_in2", W'(sb_in2), iss ? W'(b[4*n +: 4]) : 0);
      chk("sb_in3", W'(sb_in3), iss ? W'(c[4*n +: 4]) : 0);
      chk("sb_r", W'(sb_r), W'({iss ? d[7:4] : 4'h0, plo}));
      if (iss && n == 4) chk("sb_r_hi_a5", W'(sb_r[7:4]), 4'hA);
      if (n == 5 && plo == 4'h5 && mode != 2) chk("sb_r_lo_a5", W'(sb_r[3:0]), 4'h5);
      if (cyc == 1) begin
`ifdef GIFT_SBOX_SCHED_CLR_EN
        chk("clr_out1", st_out1, 0);
        chk("clr_out2", st_out2, 0);
        chk("clr_out3", st_out3, 0);
`else
        chk("keep_out1", st_out1, prev1);
        chk("keep_out2", st_out2, prev2);
        chk("keep_out3", st_out3, prev3);
`endif
      end
      @(posedge clk); #1;
      plo = iss ? d[3:0] : 4'h0;
      n += int'(iss);
      bub += int'(!iss);
    end
    chk("timeout", W'(n), NIB);
    rnd_valid = 1'($urandom); rnd_data = 8'($urandom); start = 1'($urandom);
    @(negedge clk);
    chk("flush_busy", W'(busy), 1);
    chk("flush_done", W'(done), 0);
    chk("flush_ready", W'(rnd_ready), 0);
    chk("flush_sb", W'({sb_in1, sb_in2, sb_in3, sb_r}), W'(plo));
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("done", W'(done), 1);
    chk("done_busy", W'(busy), 0);
    chk("done_at", W'(cyc + 2), mode == 0 ? 18 : mode == 1 ? 20 : W'(NIB + 2 + bub));
    chk("out1", st_out1, a);
    chk("out2", st_out2, b);
    chk("out3", st_out3, c);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", W'(busy), 0);
      chk("idle_done", W'(done), 0);
      chk("hold_out1", st_out1, a);
    end
    prev1 = a; prev2 = b; prev3 = c;
  endtask
  initial begin
    #2;
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_layer(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 64'h0, 0, -1);
    run_layer(64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 64'h0, 1, -1);
    run_layer({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 8);
    run_layer({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, -1);
    for (int t = 0; t < 6; t++)
      run_layer({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 2, -1);
    run_layer(64'h0, 64'h0, 64'h0, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
